// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Fetch/issue FSM for the serial micro-coded CPU; paces the serial
//            memory exchange and computes the next PC / micro-PC.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int MPC_WIDTH   = 9,
    parameter int INST_WIDTH  = 32,
    parameter int MINST_WIDTH = 44,
    parameter int TIMEOUT     = 64
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic                 mem_rdy,
    input  logic [MPC_WIDTH-1:0] mpc_base,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [MPC_WIDTH-1:0] m_pc,
    input  logic                 exec_done,
    input  logic                 exec_last,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    output logic [2:0]           cpu_state,
    output logic                 inst_shift_en,
    output logic                 minst_shift_en,
    output logic                 minst_valid,
    output logic                 load_pc_en,
    output logic [PC_WIDTH-1:0]  next_pc,
    output logic                 load_m_pc_en,
    output logic [MPC_WIDTH-1:0] next_m_pc,
    output logic                 fetch_err
);

    typedef enum logic [2:0] {
        SEND_PC    = 3'd0,
        WAIT_INST  = 3'd1,
        RECV_INST  = 3'd2,
        DECODE     = 3'd3,
        SEND_MPC   = 3'd4,
        WAIT_MINST = 3'd5,
        RECV_MINST = 3'd6,
        EXEC       = 3'd7
    } state_t;

    localparam int                  c_WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0]          c_PC_LAST    = 6'(PC_WIDTH - 1);
    localparam logic [5:0]          c_MPC_LAST   = 6'(MPC_WIDTH - 1);
    localparam logic [5:0]          c_INST_LAST  = 6'(INST_WIDTH - 1);
    localparam logic [5:0]          c_MINST_LAST = 6'(MINST_WIDTH - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [5:0]          r_bit_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_fetch_err;
    logic                w_timeout;
    logic                w_bit_state;
    logic                w_wait_state;

    assign w_bit_state  = (r_state == SEND_PC) || (r_state == RECV_INST) ||
                          (r_state == SEND_MPC) || (r_state == RECV_MINST);
    assign w_wait_state = (r_state == WAIT_INST) || (r_state == WAIT_MINST);

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        load_pc_en   = 1'b0;
        next_pc      = '0;
        load_m_pc_en = 1'b0;
        next_m_pc    = '0;
        case (r_state)
            SEND_PC: begin
                if (r_bit_cnt == c_PC_LAST) w_next_state = WAIT_INST;
            end
            WAIT_INST: begin
                // A ready arriving on the last allowed wait cycle beats the timeout.
                if (mem_rdy) begin
                    w_next_state = RECV_INST;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = SEND_PC;
                end
            end
            RECV_INST: begin
                if (r_bit_cnt == c_INST_LAST) w_next_state = DECODE;
            end
            DECODE: begin
                load_m_pc_en = 1'b1;
                next_m_pc    = mpc_base;
                w_next_state = SEND_MPC;
            end
            SEND_MPC: begin
                if (r_bit_cnt == c_MPC_LAST) w_next_state = WAIT_MINST;
            end
            WAIT_MINST: begin
                if (mem_rdy) begin
                    w_next_state = RECV_MINST;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = SEND_MPC;
                end
            end
            RECV_MINST: begin
                if (r_bit_cnt == c_MINST_LAST) w_next_state = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    if (exec_last) begin
                        load_pc_en   = 1'b1;
                        next_pc      = branch_taken ? branch_target : (pc + 1'b1);
                        w_next_state = SEND_PC;
                    end else begin
                        load_m_pc_en = 1'b1;
                        next_m_pc    = m_pc + 1'b1;
                        w_next_state = SEND_MPC;
                    end
                end
            end
            default: w_next_state = SEND_PC;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state     <= SEND_PC;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Both counters restart on every state change so each phase counts from 0.
            if (w_next_state != r_state) begin
                r_bit_cnt  <= '0;
                r_wait_cnt <= '0;
            end else begin
                if (w_bit_state)  r_bit_cnt  <= r_bit_cnt + 6'd1;
                if (w_wait_state) r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) r_fetch_err <= 1'b1;
        end
    end

    assign cpu_state      = r_state;
    assign inst_shift_en  = (r_state == RECV_INST);
    assign minst_shift_en = (r_state == RECV_MINST);
    assign minst_valid    = (r_state == EXEC);
    assign fetch_err      = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer; per-cycle expected
//            outputs are queued as stimulus is driven and compared at negedge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PCW  = 8;
    localparam int MPCW = 9;

    logic            sys_clk       = 1'b0;
    logic            sys_reset     = 1'b1;
    logic            mem_rdy       = 1'b0;
    logic            exec_done     = 1'b0;
    logic            exec_last     = 1'b0;
    logic            branch_taken  = 1'b0;
    logic [MPCW-1:0] mpc_base      = '0;
    logic [MPCW-1:0] m_pc          = '0;
    logic [PCW-1:0]  pc            = '0;
    logic [PCW-1:0]  branch_target = '0;

    logic [2:0]      cpu_state;
    logic            inst_shift_en;
    logic            minst_shift_en;
    logic            minst_valid;
    logic            load_pc_en;
    logic [PCW-1:0]  next_pc;
    logic            load_m_pc_en;
    logic [MPCW-1:0] next_m_pc;
    logic            fetch_err;

    fetch_sequencer dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .mem_rdy        (mem_rdy),
        .mpc_base       (mpc_base),
        .pc             (pc),
        .m_pc           (m_pc),
        .exec_done      (exec_done),
        .exec_last      (exec_last),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .cpu_state      (cpu_state),
        .inst_shift_en  (inst_shift_en),
        .minst_shift_en (minst_shift_en),
        .minst_valid    (minst_valid),
        .load_pc_en     (load_pc_en),
        .next_pc        (next_pc),
        .load_m_pc_en   (load_m_pc_en),
        .next_m_pc      (next_m_pc),
        .fetch_err      (fetch_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string       tag;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_run   = 0;
    int   n_fail  = 0;
    bit   exp_err = 1'b0;

    // {state, inst_en, minst_en, valid, ld_pc, next_pc, ld_mpc, next_m_pc, err}
    logic [25:0] w_obs;
    assign w_obs = {cpu_state, inst_shift_en, minst_shift_en, minst_valid,
                    load_pc_en, next_pc, load_m_pc_en, next_m_pc, fetch_err};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_run++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [25:0] ev(input int st, input bit ldp, input logic [PCW-1:0] np,
                                       input bit ldm, input logic [MPCW-1:0] nm);
        logic [2:0] s;
        s = 3'(st);
        return {s, (st == 2), (st == 6), (st == 7), ldp, np, ldm, nm, exp_err};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    always @(negedge sys_clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, 32'(w_obs), 32'(e.v));
        end
    end

    task automatic step(input string tag, input bit rst, input bit rdy, input bit done,
                        input bit last, input bit taken, input logic [25:0] e);
        @(posedge sys_clk);
        #1;
        sys_reset    = rst;
        mem_rdy      = rdy;
        exec_done    = done;
        exec_last    = last;
        branch_taken = taken;
        sb.push_back('{tag, e});
    endtask

    // Fixed-length phase; mem_rdy/exec_done are noise here and must be ignored.
    task automatic phase(input string tag, input int st, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, rb(), rb(), rb(), rb(), ev(st, 1'b0, '0, 1'b0, '0));
    endtask

    task automatic wait_ph(input string tag, input int st, input int waits);
        for (int i = 0; i < waits; i++)
            step(tag, 1'b0, 1'b0, rb(), rb(), rb(), ev(st, 1'b0, '0, 1'b0, '0));
        step(tag, 1'b0, 1'b1, rb(), rb(), rb(), ev(st, 1'b0, '0, 1'b0, '0));
    endtask

    task automatic timeout_ph(input string tag, input int st);
        for (int i = 0; i < 64; i++)
            step(tag, 1'b0, 1'b0, rb(), rb(), rb(), ev(st, 1'b0, '0, 1'b0, '0));
        exp_err = 1'b1;
    endtask

    task automatic exec_ph(input int dly, input bit last, input bit taken);
        logic [PCW-1:0]  np;
        logic [MPCW-1:0] nm;
        for (int i = 0; i < dly; i++)
            step("exec_wait", 1'b0, rb(), 1'b0, rb(), rb(), ev(7, 1'b0, '0, 1'b0, '0));
        if (last) begin
            np = taken ? branch_target : pc + 8'd1;
            step("exec_last", 1'b0, rb(), 1'b1, 1'b1, taken, ev(7, 1'b1, np, 1'b0, '0));
        end else begin
            nm = m_pc + 9'd1;
            step("exec_next", 1'b0, rb(), 1'b1, 1'b0, taken, ev(7, 1'b0, '0, 1'b1, nm));
        end
    endtask

    task automatic run_instr(input logic [MPCW-1:0] base, input int nuops, input logic [PCW-1:0] p,
                             input bit taken, input logic [PCW-1:0] tgt, input int iw,
                             input int mw, input int edly, input bit inst_to);
        @(negedge sys_clk);
        #1;
        pc            = p;
        mpc_base      = base;
        branch_target = tgt;
        if (inst_to) begin
            phase("send_pc", 0, 8);
            timeout_ph("wait_inst_to", 1);
        end
        phase("send_pc", 0, 8);
        wait_ph("wait_inst", 1, iw);
        phase("recv_inst", 2, 32);
        step("decode", 1'b0, rb(), rb(), rb(), rb(), ev(3, 1'b0, '0, 1'b1, base));
        for (int u = 0; u < nuops; u++) begin
            phase("send_mpc", 4, 9);
            wait_ph("wait_minst", 5, mw);
            phase("recv_minst", 6, 43);
            @(negedge sys_clk);
            #1;
            m_pc = base + 9'(u);
            phase("recv_minst", 6, 1);
            exec_ph(edly, (u == nuops - 1), taken);
        end
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 1'b0, '0, 1'b0, '0));
        step("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ev(0, 1'b0, '0, 1'b0, '0));

        // Minimum 97-cycle instruction, pc 5 -> 6
        run_instr(9'd10, 1, 8'd5, 1'b0, 8'h00, 0, 0, 0, 1'b0);
        // Three micro-ops from base 320 with memory waits
        run_instr(9'd320, 3, 8'd7, 1'b0, 8'h00, 2, 1, 3, 1'b0);
        // Branch taken: first pass only bumps micro-PC, last pass loads target
        run_instr(9'd100, 2, 8'd9, 1'b1, 8'h40, 0, 0, 0, 1'b0);
        // Wrap of both counters; ready on the last allowed wait cycle
        run_instr(9'd511, 2, 8'hFF, 1'b0, 8'h00, 1, 63, 1, 1'b0);
        // Instruction fetch timeout, then a good retry with sticky error
        run_instr(9'd5, 1, 8'h20, 1'b0, 8'h00, 0, 0, 0, 1'b1);

        // Reset at RECV_MINST bit 20
        phase("send_pc", 0, 8);
        wait_ph("wait_inst", 1, 0);
        phase("recv_inst", 2, 32);
        step("decode", 1'b0, rb(), rb(), rb(), rb(), ev(3, 1'b0, '0, 1'b1, mpc_base));
        phase("send_mpc", 4, 9);
        wait_ph("wait_minst", 5, 0);
        phase("recv_minst", 6, 20);
        step("rst_bit20", 1'b1, rb(), rb(), rb(), rb(), ev(6, 1'b0, '0, 1'b0, '0));
        exp_err = 1'b0;
        run_instr(9'd3, 1, 8'h30, 1'b0, 8'h00, 0, 0, 0, 1'b0);

        repeat (3) @(posedge sys_clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
